mem_arbiter: RTL and testbench

//  Shares the single byte-wide RAM/IO port between the instruction fetcher (32-bit reads) and the LSB (b/h/w loads and stores).

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arb_rr.sv | 10 +
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: access sizes, FSM encodings and grant ids shared by the memory arbiter.
package mem_arbiter_pkg;
   localparam logic [1:0] MEM_SIZE_B = 2'b00;
   localparam logic [1:0] MEM_SIZE_H = 2'b01;
   localparam logic [1:0] MEM_SIZE_W = 2'b10;
   localparam logic [1:0] MEMARB_IDLE  = 2'd0;
   localparam logic [1:0] MEMARB_IF_RD = 2'd1;
   localparam logic [1:0] MEMARB_LS_RD = 2'd2;
   localparam logic [1:0] MEMARB_LS_WR = 2'd3;
   localparam logic MEMARB_GRANT_IF = 1'b0;
   localparam logic MEMARB_GRANT_LS = 1'b1;
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      return size == MEM_SIZE_B ? 3'd1 : size == MEM_SIZE_H ? 3'd2 : 3'd4;
   endfunction
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: 2-way round-robin picker; on a tie the requester not granted last wins.
module mem_arb_rr import mem_arbiter_pkg::*; (
   input  logic       if_req_i,
   input  logic       ls_req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);
   assign gnt_o[0] = if_req_i && (!ls_req_i || last_i == MEMARB_GRANT_LS);
   assign gnt_o[1] = ls_req_i && (!if_req_i || last_i == MEMARB_GRANT_IF);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM/IO port between fetch and LSB, one byte per cycle, little-endian.
// Optional MEM_ARB_IO_STALL_EN holds IO-region store bytes while the UART TX buffer is full.
module mem_arbiter import mem_arbiter_pkg::*; #(
   parameter int         ADDR_W     = 32,
   parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full,
   input  logic              flush,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_data,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [1:0]        ls_size,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_done,
   output logic [31:0]       ls_rdata
);
   logic [1:0]        state_q, state_d;
   logic [2:0]        iss_q, iss_d, cap_q, cap_d, len_q, len_d;
   logic              vld_q, vld_d, last_q, last_d, if_done_q, if_done_d, ls_done_q, ls_done_d;
   logic [ADDR_W-1:0] addr_q, addr_d, cur_a;
   logic [31:0]       wdata_q, wdata_d, data_q, data_d;
   logic [1:0]        gnt;
   logic              idle, rd, wr, issue, io_stall, gnt_ok;
   assign idle   = state_q == MEMARB_IDLE;
   assign rd     = state_q == MEMARB_IF_RD || state_q == MEMARB_LS_RD;
   assign wr     = state_q == MEMARB_LS_WR;
   assign cur_a  = addr_q + ADDR_W'(iss_q);
   assign issue  = rd && iss_q < len_q;
   assign gnt_ok = idle && rdy_in && !flush && !if_done_q && !ls_done_q;
`ifdef MEM_ARB_IO_STALL_EN
   assign io_stall = wr && cur_a[17:16] == IO_ADDR_HI && io_buffer_full;
`else
   assign io_stall = 1'b0 & io_buffer_full;
`endif
   mem_arb_rr u_rr (
      .if_req_i(if_req && gnt_ok),
      .ls_req_i(ls_req && gnt_ok),
      .last_i  (last_q),
      .gnt_o   (gnt)
   );
   assign mem_wr   = wr && rdy_in && !io_stall;
   assign mem_a    = (issue || wr) ? cur_a : '0;
   assign mem_dout = wr ? wdata_q[{iss_q[1:0], 3'b000} +: 8] : 8'h00;
   assign if_done  = if_done_q && rdy_in;
   assign ls_done  = ls_done_q && rdy_in;
   assign if_data  = data_q;
   assign ls_rdata = data_q;
   // A pause rewinds issue to capture: the byte returned during the pause was never stored.
   always_comb begin
      state_d   = state_q;
      iss_d     = iss_q;
      cap_d     = cap_q;
      len_d     = len_q;
      vld_d     = 1'b0;
      last_d    = last_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      data_d    = data_q;
      if_done_d = 1'b0;
      ls_done_d = 1'b0;
      if (!rdy_in) begin
         iss_d     = rd ? cap_q : iss_q;
         if_done_d = if_done_q;
         ls_done_d = ls_done_q;
      end else if (idle) begin
         if (|gnt) begin
            state_d = gnt[0] ? MEMARB_IF_RD : ls_we ? MEMARB_LS_WR : MEMARB_LS_RD;
            addr_d  = gnt[0] ? if_addr : ls_addr;
            len_d   = gnt[0] ? 3'd4 : size_bytes(ls_size);
            last_d  = gnt[1] ? MEMARB_GRANT_LS : MEMARB_GRANT_IF;
            wdata_d = ls_wdata;
            data_d  = '0;
            iss_d   = '0;
            cap_d   = '0;
         end
      end else if (wr) begin
         if (!io_stall) begin
            iss_d     = iss_q + 3'd1;
            state_d   = iss_d == len_q ? MEMARB_IDLE : state_q;
            ls_done_d = iss_d == len_q;
         end
      end else if (flush) begin
         state_d = MEMARB_IDLE;
      end else begin
         iss_d = iss_q + {2'b00, issue};
         vld_d = issue;
         if (vld_q) begin
            data_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
            cap_d = cap_q + 3'd1;
            if (cap_d == len_q) begin
               state_d   = MEMARB_IDLE;
               if_done_d = state_q == MEMARB_IF_RD;
               ls_done_d = state_q == MEMARB_LS_RD;
            end
         end
      end
   end
   // last_q resets to LS so the fetcher wins the first tie after reset.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q   <= MEMARB_IDLE;
         iss_q     <= '0;
         cap_q     <= '0;
         len_q     <= '0;
         vld_q     <= 1'b0;
         last_q    <= MEMARB_GRANT_LS;
         addr_q    <= '0;
         wdata_q   <= '0;
         data_q    <= '0;
         if_done_q <= 1'b0;
         ls_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         iss_q     <= iss_d;
         cap_q     <= cap_d;
         len_q     <= len_d;
         vld_q     <= vld_d;
         last_q    <= last_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         data_q    <= data_d;
         if_done_q <= if_done_d;
         ls_done_q <= ls_done_d;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a byte RAM with one-cycle read latency.
module tb_mem_arbiter;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, io_buffer_full, flush;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        if_req, if_done, ls_req, ls_we, ls_done;
   logic [31:0] if_addr, if_data, ls_addr, ls_wdata, ls_rdata;
   logic [1:0]  ls_size;
   logic [7:0]  ram [0:1023];
   logic        ld_en;
   logic [9:0]  ld_a;
   logic [7:0]  ld_d;
   int          errors = 0;
   int          checks = 0;
   int          pa [14] = '{'h100, 'h101, 'h102, 'h103, 'h104, 'h105, 'h106, 'h107, 'h300, 'h301, 'h200, 'h20A, 'h20B, 'h000};
   int          pd [14] = '{'h13, 'h05, 'h00, 'h00, 'h11, 'h22, 'h33, 'h44, 'hFE, 'hFF, 'h00, 'h00, 'h00, 'h00};

   mem_arbiter dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      if (ld_en) ram[ld_a] <= ld_d;
      else if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
      mem_din <= ram[mem_a[9:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_in);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ifd, lsd, wrn, fw;
      logic [31:0] wa, rdv, ifv;
      rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
      if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00;
      ls_addr = '0; ls_wdata = '0; ld_en = 1'b0; ld_a = '0; ld_d = '0;
      step(); step();
      for (int i = 0; i < 14; i++) begin
         ld_a = 10'(pa[i]); ld_d = 8'(pd[i]); ld_en = 1'b1;
         step();
      end
      ld_en = 1'b0;
      chk("rst_mem_a", mem_a, 0);
      chk("rst_mem_wr", 32'(mem_wr), 0);
      chk("rst_mem_dout", 32'(mem_dout), 0);
      chk("rst_done", 32'({if_done, ls_done}), 0);
      chk("rst_data", if_data | ls_rdata, 0);
      rst_in = 1'b1;
      step();
      // 1: word fetch
      if_req = 1'b1; if_addr = 32'h100;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk($sformatf("t1_mem_a_c%0d", k), mem_a, k <= 4 ? 32'h100 + k - 1 : 0);
         chk($sformatf("t1_mem_wr_c%0d", k), 32'(mem_wr), 0);
         chk($sformatf("t1_if_done_c%0d", k), 32'(if_done), 32'(k == 6));
      end
      chk("t1_if_data", if_data, 32'h0000_0513);
      if_req = 1'b0;
      step();
      // 2: tie after reset, then sb after the bubble
      rst_in = 1'b0;
      step();
      rst_in = 1'b1;
      if_req = 1'b1; if_addr = 32'h100;
      ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h200; ls_wdata = 32'h0000_00AB;
      ifd = 0; lsd = 0; wrn = 0; wa = '0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (mem_wr) begin wrn++; wa = mem_a; end
         if (if_done) begin ifd = k; if_req = 1'b0; end
         if (ls_done) begin lsd = k; ls_req = 1'b0; end
      end
      chk("t2_if_done_cyc", ifd, 6);
      chk("t2_ls_done_cyc", lsd, 9);
      chk("t2_wr_count", wrn, 1);
      chk("t2_wr_addr", wa, 32'h200);
      chk("t2_ram_200", 32'(ram[10'h200]), 32'hAB);
      // 3: lh, then a fetch flushed at its byte 1
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b01; ls_addr = 32'h300;
      ifd = 0; lsd = 0; rdv = '0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (ls_done) begin lsd = k; rdv = ls_rdata; ls_req = 1'b0; end
         if (if_done) ifd++;
         if (k == 1) begin if_req = 1'b1; if_addr = 32'h100; end
         if (k == 7) begin chk("t3_byte1_addr", mem_a, 32'h101); flush = 1'b1; if_req = 1'b0; end
         if (k == 8) begin chk("t3_idle_after_flush", mem_a, 0); flush = 1'b0; end
      end
      chk("t3_ls_done_cyc", lsd, 4);
      chk("t3_lh_data", rdv, 32'h0000_FFFE);
      chk("t3_no_if_done", ifd, 0);
      // 4: rdy_in low for 3 cycles during lw
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h104;
      lsd = 0; wrn = 0; rdv = '0;
      for (int k = 1; k <= 14; k++) begin
         step();
         if (k == 3) rdy_in = 1'b0;
         if (k == 6) begin rdy_in = 1'b1; #1; chk("t4_reread_addr", mem_a, 32'h105); end
         if (mem_wr) wrn++;
         if (ls_done) begin lsd = k; rdv = ls_rdata; ls_req = 1'b0; end
      end
      chk("t4_ls_done_cyc", lsd, 10);
      chk("t4_lw_data", rdv, 32'h4433_2211);
      chk("t4_no_write", wrn, 0);
      // 5: sb to the IO region with the TX buffer full for 5 cycles
      io_buffer_full = 1'b1;
      ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h0003_0000; ls_wdata = 32'h0000_0041;
      lsd = 0; wrn = 0; fw = 0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 6) begin io_buffer_full = 1'b0; #1; end
         if (mem_wr) begin wrn++; if (fw == 0) fw = k; end
         if (ls_done) begin lsd = k; ls_req = 1'b0; end
      end
`ifdef MEM_ARB_IO_STALL_EN
      chk("t5_wr_cyc", fw, 6);
      chk("t5_done_cyc", lsd, 7);
`else
      chk("t5_wr_cyc", fw, 1);
      chk("t5_done_cyc", lsd, 2);
`endif
      chk("t5_wr_count", wrn, 1);
      chk("t5_ram_io", 32'(ram[10'h000]), 32'h41);
      // 6: reset during byte 2 of sw
      ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h208; ls_wdata = 32'hDDCC_BBAA;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("t6_mem_wr_c%0d", k), 32'(mem_wr), 1);
         chk($sformatf("t6_mem_a_c%0d", k), mem_a, 32'h208 + k - 1);
      end
      rst_in = 1'b0;
      step();
      chk("t6_rst_mem_a", mem_a, 0);
      chk("t6_rst_mem_wr", 32'(mem_wr), 0);
      chk("t6_rst_mem_dout", 32'(mem_dout), 0);
      chk("t6_rst_done", 32'({if_done, ls_done}), 0);
      chk("t6_rst_data", if_data | ls_rdata, 0);
      rst_in = 1'b1; ls_req = 1'b0;
      step();
      chk("t6_ram_20a", 32'(ram[10'h20A]), 32'hCC);
      chk("t6_ram_20b", 32'(ram[10'h20B]), 32'h00);
      if_req = 1'b1; if_addr = 32'h100;
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h301;
      ifd = 0; lsd = 0; ifv = '0; rdv = '0;
      for (int k = 1; k <= 14; k++) begin
         step();
         if (if_done) begin ifd = k; ifv = if_data; if_req = 1'b0; end
         if (ls_done) begin lsd = k; rdv = ls_rdata; ls_req = 1'b0; end
      end
      chk("t6_if_done_cyc", ifd, 6);
      chk("t6_if_data", ifv, 32'h0000_0513);
      chk("t6_ls_done_cyc", lsd, 10);
      chk("t6_lb_data", rdv, 32'h0000_00FF);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
